// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
// Background scrubber for a SECDED-protected memory. It walks every address,
// reads the codeword, runs it through an external combinational SECDED
// decoder, and writes back a re-encoded word whenever a single-bit error was
// corrected. The host always has priority on the memory port. Error counts and
// the most recent uncorrectable address are kept for software.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   scrub_en_i          enable background scrubbing
//   host_busy_i         host owns the memory port this cycle
//   host_wr_i/addr_i    snooped host write strobe and address
//   mem_req_o/we_o      scrubber access request, 1 = write
//   mem_addr_o          access address
//   mem_wdata_o         write codeword
//   mem_rdata_i         read codeword, valid RD_LAT cycles after issue
//   dec_cw_o            captured codeword to the decoder
//   dec_data_i          corrected data from the decoder
//   dec_sec_i/ded_i     decoder single-corrected / double-detected flags
//   enc_data_o          data to the encoder
//   enc_cw_i            encoder codeword output
//   busy_o              scrubber is not idle
//   pass_done_o         one-cycle pulse after the last address of a pass
//   cnt_sec_o/ded_o     saturating corrected / uncorrectable counts
//   ded_valid_o         sticky: an uncorrectable error has been logged
//   ded_addr_o          address of the most recent uncorrectable error
`timescale 1ns/1ps
module ecc_scrub_ctrl #(
    parameter int DATA_W    = 64,
    parameter int RED_W     = 8,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int INTERVAL  = 1024,
    parameter int RD_LAT    = 1,
    localparam int CW_W     = DATA_W + RED_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scrub_en_i,
    input  logic              host_busy_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [CW_W-1:0]   mem_wdata_o,
    input  logic [CW_W-1:0]   mem_rdata_i,
    output logic [CW_W-1:0]   dec_cw_o,
    input  logic [DATA_W-1:0] dec_data_i,
    input  logic              dec_sec_i,
    input  logic              dec_ded_i,
    output logic [DATA_W-1:0] enc_data_o,
    input  logic [CW_W-1:0]   enc_cw_i,
    output logic              busy_o,
    output logic              pass_done_o,
    output logic [15:0]       cnt_sec_o,
    output logic [15:0]       cnt_ded_o,
    output logic              ded_valid_o,
    output logic [ADDR_W-1:0] ded_addr_o
);

    localparam int INT_W = $clog2(INTERVAL + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_RD, ST_RWAIT, ST_CHK, ST_WR, ST_NEXT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] scrubAddr_q;
    logic [INT_W-1:0]  intervalCnt_q;
    logic [LAT_W-1:0]  latCnt_q;
    logic [CW_W-1:0]   cw_q;
    logic [DATA_W-1:0] data_q;
    logic              abort_q;
    logic              passDone_q;
    logic [15:0]       cntSec_q;
    logic [15:0]       cntDed_q;
    logic              dedValid_q;
    logic [ADDR_W-1:0] dedAddr_q;

    logic              addrHit;
    logic              abortNow;
    logic              rdIssue;
    logic              wrIssue;
    logic [15:0]       cntSec_d;
    logic [15:0]       cntDed_d;

    // A host write to the word we are working on makes our copy stale, so any
    // pending write-back for it must be dropped. abortNow also covers a host
    // write landing in the very cycle the write-back would issue.
    assign addrHit  = host_wr_i && (host_addr_i == scrubAddr_q);
    assign abortNow = abort_q || addrHit;
    assign rdIssue  = (state_q == ST_RD) && !host_busy_i;
    assign wrIssue  = (state_q == ST_WR) && !host_busy_i && !abortNow;

    // Saturating next values for the error counters.
    assign cntSec_d = (cntSec_q == 16'hFFFF) ? cntSec_q : cntSec_q + 16'd1;
    assign cntDed_d = (cntDed_q == 16'hFFFF) ? cntDed_q : cntDed_q + 16'd1;

    // The memory request has to back off in the same cycle the host claims the
    // port, so it is decoded from the state and host_busy_i rather than
    // registered. Everything else comes straight from registers.
    assign mem_req_o   = rdIssue || wrIssue;
    assign mem_we_o    = (state_q == ST_WR);
    assign mem_addr_o  = scrubAddr_q;
    assign mem_wdata_o = (state_q == ST_WR) ? enc_cw_i : '0;
    assign dec_cw_o    = cw_q;
    assign enc_data_o  = data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign pass_done_o = passDone_q;
    assign cnt_sec_o   = cntSec_q;
    assign cnt_ded_o   = cntDed_q;
    assign ded_valid_o = dedValid_q;
    assign ded_addr_o  = dedAddr_q;

    // Scrub sequencer: wait out the interval, read, check, optionally write
    // back, then step to the next address. Logging and the collision flag are
    // updated here as well so all state moves on one edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            scrubAddr_q   <= '0;
            intervalCnt_q <= '0;
            latCnt_q      <= '0;
            cw_q          <= '0;
            data_q        <= '0;
            abort_q       <= 1'b0;
            passDone_q    <= 1'b0;
            cntSec_q      <= '0;
            cntDed_q      <= '0;
            dedValid_q    <= 1'b0;
            dedAddr_q     <= '0;
        end else begin
            passDone_q <= 1'b0;

            // Collision window runs from the read issue cycle through WR.
            if (addrHit && (rdIssue || (state_q inside {ST_RWAIT, ST_CHK, ST_WR}))) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    intervalCnt_q <= '0;
                    if (scrub_en_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // No word is in flight yet, so a disable here stops at once.
                    if (!scrub_en_i) begin
                        intervalCnt_q <= '0;
                        state_q       <= ST_IDLE;
                    end else if (intervalCnt_q == INT_W'(INTERVAL - 1)) begin
                        intervalCnt_q <= '0;
                        state_q       <= ST_RD;
                    end else begin
                        intervalCnt_q <= intervalCnt_q + INT_W'(1);
                    end
                end
                ST_RD: begin
                    if (!host_busy_i) begin
                        latCnt_q <= '0;
                        state_q  <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (latCnt_q == LAT_W'(RD_LAT - 1)) begin
                        cw_q    <= mem_rdata_i;
                        state_q <= ST_CHK;
                    end else begin
                        latCnt_q <= latCnt_q + LAT_W'(1);
                    end
                end
                ST_CHK: begin
                    // Both flags together can only mean the word is unrecoverable.
                    if (dec_ded_i) begin
                        cntDed_q   <= cntDed_d;
                        dedAddr_q  <= scrubAddr_q;
                        dedValid_q <= 1'b1;
                        state_q    <= ST_NEXT;
                    end else if (dec_sec_i) begin
                        data_q  <= dec_data_i;
                        state_q <= ST_WR;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_WR: begin
                    if (abortNow) begin
                        state_q <= ST_NEXT;
                    end else if (!host_busy_i) begin
                        cntSec_q <= cntSec_d;
                        state_q  <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    abort_q       <= 1'b0;
                    intervalCnt_q <= '0;
                    if (scrubAddr_q == ADDR_W'(MEM_DEPTH - 1)) begin
                        scrubAddr_q <= '0;
                        passDone_q  <= 1'b1;
                    end else begin
                        scrubAddr_q <= scrubAddr_q + ADDR_W'(1);
                    end
                    state_q <= scrub_en_i ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl
// Directed bench for ecc_scrub_ctrl with a small 8-word memory. The memory,
// encoder and decoder live in the bench. The code is a toy triple-repetition
// code: it corrects any single flipped bit and flags two flips in different
// bit positions as uncorrectable, which is all the directed cases need.
`timescale 1ns/1ps
module tb_ecc_scrub_ctrl;

    localparam int DATA_W    = 4;
    localparam int RED_W     = 8;
    localparam int CW_W      = DATA_W + RED_W;
    localparam int ADDR_W    = 3;
    localparam int MEM_DEPTH = 8;
    localparam int INTERVAL  = 4;
    localparam int RD_LAT    = 1;

    logic              clk;
    logic              rst;
    logic              scrubEn;
    logic              hostBusy;
    logic              hostWr;
    logic [ADDR_W-1:0] hostAddr;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [CW_W-1:0]   memWdata;
    logic [CW_W-1:0]   memRdata;
    logic [CW_W-1:0]   decCw;
    logic [DATA_W-1:0] decData;
    logic              decSec;
    logic              decDed;
    logic [DATA_W-1:0] encData;
    logic [CW_W-1:0]   encCw;
    logic              busy;
    logic              passDone;
    logic [15:0]       cntSec;
    logic [15:0]       cntDed;
    logic              dedValid;
    logic [ADDR_W-1:0] dedAddr;

    int checks;
    int errors;

    logic [CW_W-1:0]   mem [MEM_DEPTH];
    int                rdCount;
    int                wrCount;
    int                passCount;
    int                busyViol;
    logic [ADDR_W-1:0] lastRdAddr;
    logic [ADDR_W-1:0] lastWrAddr;
    logic [CW_W-1:0]   lastWrData;
    int                nDis;

    ecc_scrub_ctrl #(
        .DATA_W(DATA_W), .RED_W(RED_W), .ADDR_W(ADDR_W),
        .MEM_DEPTH(MEM_DEPTH), .INTERVAL(INTERVAL), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .scrub_en_i(scrubEn),
        .host_busy_i(hostBusy), .host_wr_i(hostWr), .host_addr_i(hostAddr),
        .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
        .dec_cw_o(decCw), .dec_data_i(decData), .dec_sec_i(decSec), .dec_ded_i(decDed),
        .enc_data_o(encData), .enc_cw_i(encCw),
        .busy_o(busy), .pass_done_o(passDone),
        .cnt_sec_o(cntSec), .cnt_ded_o(cntDed),
        .ded_valid_o(dedValid), .ded_addr_o(dedAddr)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder: three copies of the data word.
    assign encCw = {encData, encData, encData};

    // Decoder: per-bit majority vote; the number of bit positions whose copies
    // disagree tells a single flip from a double flip.
    always_comb begin
        decData = '0;
        nDis    = 0;
        for (int i = 0; i < DATA_W; i++) begin
            decData[i] = (decCw[i] & decCw[DATA_W+i]) | (decCw[i] & decCw[2*DATA_W+i])
                       | (decCw[DATA_W+i] & decCw[2*DATA_W+i]);
            if ((decCw[i] != decCw[DATA_W+i]) || (decCw[i] != decCw[2*DATA_W+i])) begin
                nDis++;
            end
        end
        decSec = (nDis == 1);
        decDed = (nDis >= 2);
    end

    // Memory model and transaction monitor: serves scrubber reads one cycle
    // after issue, applies scrubber writes, and logs every access.
    always @(posedge clk) begin
        if (passDone) passCount++;
        if (memReq && hostBusy) busyViol++;
        if (memReq) begin
            if (memWe) begin
                wrCount++;
                lastWrAddr = memAddr;
                lastWrData = memWdata;
                mem[memAddr] = memWdata;
            end else begin
                rdCount++;
                lastRdAddr = memAddr;
                memRdata <= mem[memAddr];
            end
        end
    end

    // Safety net in case a scenario wedges despite its own bounds.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CW_W-1:0] goldCw(input int i);
        logic [DATA_W-1:0] d;
        d = DATA_W'(i * 3 + 5);
        return {d, d, d};
    endfunction

    task automatic initMem();
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = goldCw(i);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        scrubEn  = 1'b0;
        hostBusy = 1'b0;
        hostWr   = 1'b0;
        hostAddr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs until the next pass_done pulse, then disables and waits for idle.
    // rdD/wrD are the accesses seen up to the pass boundary.
    task automatic runPass(output int rdD, output int wrD);
        int r0, w0, p0, n;
        r0 = rdCount; w0 = wrCount; p0 = passCount;
        @(negedge clk);
        scrubEn = 1'b1;
        n = 0;
        while (passCount == p0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rdD = rdCount - r0;
        wrD = wrCount - w0;
        checks++;
        if (passCount == p0) begin
            errors++;
            $display("[TB] FAIL pass_timeout: got %0d passes expected 1", passCount - p0);
        end
        scrubEn = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (memReq !== 1'b0)   begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", memReq); end
        checks++; if (passDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_pass: got %b expected 0", passDone); end
        checks++; if (cntSec !== 16'd0)  begin errors++; $display("[TB] FAIL rst_sec: got %h expected 0", cntSec); end
        checks++; if (cntDed !== 16'd0)  begin errors++; $display("[TB] FAIL rst_ded: got %h expected 0", cntDed); end
        checks++; if (dedValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_dedv: got %b expected 0", dedValid); end
        checks++; if (dedAddr !== 3'd0)  begin errors++; $display("[TB] FAIL rst_deda: got %0d expected 0", dedAddr); end
    endtask

    task automatic test_clean_pass();
        int rd, wr, p0;
        initMem();
        p0 = passCount;
        runPass(rd, wr);
        repeat (20) @(negedge clk);
        checks++; if (rd != 8) begin errors++; $display("[TB] FAIL clean_reads: got %0d expected 8", rd); end
        checks++; if (wr != 0) begin errors++; $display("[TB] FAIL clean_writes: got %0d expected 0", wr); end
        checks++; if (lastRdAddr !== 3'd7) begin errors++; $display("[TB] FAIL clean_last_addr: got %0d expected 7", lastRdAddr); end
        checks++; if (passCount - p0 != 1) begin errors++; $display("[TB] FAIL clean_pass_pulses: got %0d expected 1", passCount - p0); end
        checks++; if (cntSec !== 16'd0) begin errors++; $display("[TB] FAIL clean_sec: got %h expected 0", cntSec); end
        checks++; if (cntDed !== 16'd0) begin errors++; $display("[TB] FAIL clean_ded: got %h expected 0", cntDed); end
    endtask

    task automatic test_sec();
        int rd, wr;
        mem[3] = goldCw(3) ^ 12'h002;
        runPass(rd, wr);
        checks++; if (wr != 1) begin errors++; $display("[TB] FAIL sec_writes: got %0d expected 1", wr); end
        checks++; if (lastWrAddr !== 3'd3) begin errors++; $display("[TB] FAIL sec_wr_addr: got %0d expected 3", lastWrAddr); end
        checks++; if (lastWrData !== goldCw(3)) begin errors++; $display("[TB] FAIL sec_wr_data: got %h expected %h", lastWrData, goldCw(3)); end
        checks++; if (cntSec !== 16'd1) begin errors++; $display("[TB] FAIL sec_cnt: got %h expected 1", cntSec); end
        checks++; if (cntDed !== 16'd0) begin errors++; $display("[TB] FAIL sec_ded_cnt: got %h expected 0", cntDed); end
        // Second pass reads the repaired word and must find nothing to fix.
        runPass(rd, wr);
        checks++; if (wr != 0) begin errors++; $display("[TB] FAIL sec_reread_writes: got %0d expected 0", wr); end
        checks++; if (cntSec !== 16'd1) begin errors++; $display("[TB] FAIL sec_reread_cnt: got %h expected 1", cntSec); end
    endtask

    task automatic test_ded();
        int rd, wr;
        mem[5] = goldCw(5) ^ 12'h021;
        runPass(rd, wr);
        checks++; if (wr != 0) begin errors++; $display("[TB] FAIL ded_writes: got %0d expected 0", wr); end
        checks++; if (cntDed !== 16'd1) begin errors++; $display("[TB] FAIL ded_cnt: got %h expected 1", cntDed); end
        checks++; if (dedAddr !== 3'd5) begin errors++; $display("[TB] FAIL ded_addr: got %0d expected 5", dedAddr); end
        checks++; if (dedValid !== 1'b1) begin errors++; $display("[TB] FAIL ded_valid: got %b expected 1", dedValid); end
        checks++; if (cntSec !== 16'd1) begin errors++; $display("[TB] FAIL ded_sec_cnt: got %h expected 1", cntSec); end
        // Repaired memory: ded_valid stays sticky, count holds.
        mem[5] = goldCw(5);
        runPass(rd, wr);
        checks++; if (dedValid !== 1'b1) begin errors++; $display("[TB] FAIL ded_sticky: got %b expected 1", dedValid); end
        checks++; if (cntDed !== 16'd1) begin errors++; $display("[TB] FAIL ded_cnt_hold: got %h expected 1", cntDed); end
    endtask

    task automatic test_host_busy();
        int r0, w0, v0, n;
        doReset();
        initMem();
        mem[0] = goldCw(0) ^ 12'h100;
        r0 = rdCount; w0 = wrCount; v0 = busyViol;
        @(negedge clk);
        hostBusy = 1'b1;
        scrubEn  = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (rdCount != r0) begin errors++; $display("[TB] FAIL hb_rd_blocked: got %0d reads expected 0", rdCount - r0); end
        hostBusy = 1'b0;
        @(negedge clk);
        checks++; if (rdCount - r0 != 1) begin errors++; $display("[TB] FAIL hb_rd_release: got %0d reads expected 1", rdCount - r0); end
        checks++; if (lastRdAddr !== 3'd0) begin errors++; $display("[TB] FAIL hb_rd_addr: got %0d expected 0", lastRdAddr); end
        hostBusy = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (wrCount != w0) begin errors++; $display("[TB] FAIL hb_wr_blocked: got %0d writes expected 0", wrCount - w0); end
        hostBusy = 1'b0;
        scrubEn  = 1'b0;
        @(negedge clk);
        checks++; if (wrCount - w0 != 1) begin errors++; $display("[TB] FAIL hb_wr_release: got %0d writes expected 1", wrCount - w0); end
        checks++; if (lastWrData !== goldCw(0)) begin errors++; $display("[TB] FAIL hb_wr_data: got %h expected %h", lastWrData, goldCw(0)); end
        checks++; if (busyViol != v0) begin errors++; $display("[TB] FAIL hb_req_while_busy: got %0d expected 0", busyViol - v0); end
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hb_stop: got busy=%b expected 0", busy); end
        checks++; if (cntSec !== 16'd1) begin errors++; $display("[TB] FAIL hb_sec_cnt: got %h expected 1", cntSec); end
    endtask

    task automatic test_collision();
        int r0, w0, n, rd, wr;
        doReset();
        initMem();
        mem[3] = goldCw(3) ^ 12'h002;
        r0 = rdCount; w0 = wrCount;
        @(negedge clk);
        scrubEn = 1'b1;
        n = 0;
        while (!(rdCount > r0 && lastRdAddr == 3'd3) && n < 500) begin @(negedge clk); n++; end
        checks++; if (lastRdAddr !== 3'd3) begin errors++; $display("[TB] FAIL col_read_seen: got %0d expected 3", lastRdAddr); end
        // Host overwrites addr 3 with good data while the scrubber holds a stale copy.
        hostBusy = 1'b1;
        hostWr   = 1'b1;
        hostAddr = 3'd3;
        mem[3]   = goldCw(3);
        @(negedge clk);
        hostBusy = 1'b0;
        hostWr   = 1'b0;
        runPass(rd, wr);
        checks++; if (wrCount != w0) begin errors++; $display("[TB] FAIL col_writes: got %0d expected 0", wrCount - w0); end
        checks++; if (cntSec !== 16'd0) begin errors++; $display("[TB] FAIL col_sec_cnt: got %h expected 0", cntSec); end
    endtask

    task automatic test_saturation_reset();
        int rd, wr, r0, n;
        doReset();
        initMem();
        mem[1] = goldCw(1) ^ 12'h002;
        mem[2] = goldCw(2) ^ 12'h040;
        @(negedge clk);
        force dut.cntSec_q = 16'hFFFE;
        @(negedge clk);
        release dut.cntSec_q;
        runPass(rd, wr);
        checks++; if (wr != 2) begin errors++; $display("[TB] FAIL sat_writes: got %0d expected 2", wr); end
        checks++; if (cntSec !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_cnt: got %h expected ffff", cntSec); end
        // Reset while the read of addr 2 is outstanding.
        r0 = rdCount;
        @(negedge clk);
        scrubEn = 1'b1;
        n = 0;
        while (!(rdCount > r0 && lastRdAddr == 3'd2) && n < 500) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rw_rst_busy: got %b expected 0", busy); end
        checks++; if (memReq !== 1'b0)  begin errors++; $display("[TB] FAIL rw_rst_req: got %b expected 0", memReq); end
        checks++; if (cntSec !== 16'd0) begin errors++; $display("[TB] FAIL rw_rst_sec: got %h expected 0", cntSec); end
        checks++; if (dedValid !== 1'b0) begin errors++; $display("[TB] FAIL rw_rst_dedv: got %b expected 0", dedValid); end
        rst = 1'b0;
        r0 = rdCount;
        n = 0;
        while (rdCount == r0 && n < 100) begin @(negedge clk); n++; end
        checks++; if (rdCount == r0 || lastRdAddr !== 3'd0) begin errors++; $display("[TB] FAIL rw_restart_addr: got %0d expected 0", lastRdAddr); end
        scrubEn = 1'b0;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rdCount   = 0;
        wrCount   = 0;
        passCount = 0;
        busyViol  = 0;
        rst       = 1'b1;
        scrubEn   = 1'b0;
        hostBusy  = 1'b0;
        hostWr    = 1'b0;
        hostAddr  = '0;
        initMem();
        test_reset();
        test_clean_pass();
        test_sec();
        test_ded();
        test_host_busy();
        test_collision();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
